// File: rtl/result_sink.sv
// Result sink: buffers extended-format engine results in a small FIFO, presents
// each word raw and as a flag-gated IEEE value, and tracks completion and overflow.
module result_sink #(
  parameter int BIT_WIDTH   = 32,
  parameter int EXTRA_BITS  = 2,
  parameter int DEPTH       = 4,
  parameter int NUM_RESULTS = 2
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            FLUSH,
  input  logic                            IN_VALID,
  input  logic [BIT_WIDTH+EXTRA_BITS-1:0] IN_DATA,
  output logic                            IN_READY,
  output logic                            OUT_VALID,
  input  logic                            OUT_READY,
  output logic [BIT_WIDTH+EXTRA_BITS-1:0] OUT_RAW,
  output logic [BIT_WIDTH-1:0]            OUT_IEEE,
  output logic [$clog2(DEPTH):0]          LEVEL,
  output logic                            DONE,
  output logic                            OVERFLOW
);

  localparam int DW = BIT_WIDTH + EXTRA_BITS;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(NUM_RESULTS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(NUM_RESULTS);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [CW-1:0] cnt;
  logic          done;
  logic          overflow;
  logic          push;
  logic          pop;

  // Handshakes are judged on pre-edge state, so a full buffer drops a word even
  // when the same edge pops.
  assign IN_READY  = (level < LW'(DEPTH));
  assign OUT_VALID = (level != '0);
  assign push      = IN_VALID && IN_READY;
  assign pop       = OUT_VALID && OUT_READY;

  assign OUT_RAW   = OUT_VALID ? mem[rd_ptr] : '0;
  assign OUT_IEEE  = OUT_RAW[BIT_WIDTH-1:0] & {BIT_WIDTH{OUT_RAW[BIT_WIDTH]}};
  assign LEVEL     = level;
  assign DONE      = done;
  assign OVERFLOW  = overflow;

  // NOTE: the storage array has no reset; stale entries are never visible because
  // OUT_RAW is gated by OUT_VALID, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge CLK) begin
    if (push && !FLUSH) mem[wr_ptr] <= IN_DATA;
  end

  // NOTE: all state uses non-blocking assignments so every register samples the
  // same pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else if (FLUSH) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase

      if (push && cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
        if (cnt + CW'(1) == CNT_MAX) done <= 1'b1;
      end

      if (IN_VALID && !IN_READY) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_result_sink.sv
// Directed bench for result_sink: a vector table for the FIFO/flag behaviour plus
// hand-written sequences for asynchronous reset mid-operation.
module tb_result_sink;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        FLUSH = 1'b0;
  logic        IN_VALID = 1'b0;
  logic [33:0] IN_DATA = '0;
  logic        IN_READY;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [33:0] OUT_RAW;
  logic [31:0] OUT_IEEE;
  logic [2:0]  LEVEL;
  logic        DONE;
  logic        OVERFLOW;

  int checks = 0;
  int errors = 0;

  result_sink dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_READY(IN_READY),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_RAW(OUT_RAW), .OUT_IEEE(OUT_IEEE), .LEVEL(LEVEL),
    .DONE(DONE), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        flush;
    logic        in_valid;
    logic [33:0] in_data;
    logic        out_ready;
    logic        e_in_ready;
    logic        e_out_valid;
    logic [33:0] e_raw;
    logic [31:0] e_ieee;
    logic [2:0]  e_level;
    logic        e_done;
    logic        e_overflow;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic f, iv, input logic [33:0] d, input logic ordy,
                              input logic ir, ov, input logic [33:0] raw,
                              input logic [31:0] ieee, input logic [2:0] lvl,
                              input logic dn, ovf);
    vec_t v;
    v.flush = f; v.in_valid = iv; v.in_data = d; v.out_ready = ordy;
    v.e_in_ready = ir; v.e_out_valid = ov; v.e_raw = raw; v.e_ieee = ieee;
    v.e_level = lvl; v.e_done = dn; v.e_overflow = ovf;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic f, iv, input logic [33:0] d, input logic ordy);
    FLUSH = f; IN_VALID = iv; IN_DATA = d; OUT_READY = ordy;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all(input string tag, input logic ir, ov, input logic [33:0] raw,
                           input logic [31:0] ieee, input logic [2:0] lvl,
                           input logic dn, ovf);
    check({tag, ".in_ready"},  64'(IN_READY),  64'(ir));
    check({tag, ".out_valid"}, 64'(OUT_VALID), 64'(ov));
    check({tag, ".raw"},       64'(OUT_RAW),   64'(raw));
    check({tag, ".ieee"},      64'(OUT_IEEE),  64'(ieee));
    check({tag, ".level"},     64'(LEVEL),     64'(lvl));
    check({tag, ".done"},      64'(DONE),      64'(dn));
    check({tag, ".overflow"},  64'(OVERFLOW),  64'(ovf));
  endtask

  localparam logic [33:0] W1 = {2'b01, 32'h3F9D70A4};
  localparam logic [33:0] W0 = {2'b00, 32'h3F9D70A4};
  localparam logic [33:0] A  = {2'b01, 32'h11111111};
  localparam logic [33:0] B  = {2'b01, 32'h22222222};
  localparam logic [33:0] C  = {2'b01, 32'h33333333};
  localparam logic [33:0] D  = {2'b01, 32'h44444444};
  localparam logic [33:0] E  = {2'b01, 32'h55555555};
  localparam logic [33:0] F1 = {2'b11, 32'h80000001};
  localparam logic [33:0] F2 = {2'b01, 32'h00000002};
  localparam logic [33:0] F3 = {2'b01, 32'h00000003};
  localparam logic [33:0] F4 = {2'b01, 32'h00000004};
  localparam logic [33:0] F5 = {2'b10, 32'hFFFFFFFF};
  localparam logic [33:0] F6 = {2'b01, 32'h00000006};
  localparam logic [33:0] F7 = {2'b01, 32'h00000007};
  localparam logic [33:0] F8 = {2'b01, 32'h00000008};
  localparam logic [33:0] G  = {2'b01, 32'hCAFE0001};
  localparam logic [33:0] H  = {2'b01, 32'hCAFE0002};

  initial begin
    // flush valid data ready | in_ready out_valid raw ieee level done overflow
    vecs.push_back(mk(0,1,W1,0, 1,1,W1,32'h3F9D70A4,3'd1,0,0));
    vecs.push_back(mk(0,0,'0,1, 1,0,'0,32'h0,3'd0,0,0));
    vecs.push_back(mk(0,1,W0,0, 1,1,W0,32'h0,3'd1,1,0));
    vecs.push_back(mk(1,0,'0,0, 1,0,'0,32'h0,3'd0,0,0));
    // fill to full, overflow, drop while popping, drain in order
    vecs.push_back(mk(0,1,A,0, 1,1,A,32'h11111111,3'd1,0,0));
    vecs.push_back(mk(0,1,B,0, 1,1,A,32'h11111111,3'd2,1,0));
    vecs.push_back(mk(0,1,C,0, 1,1,A,32'h11111111,3'd3,1,0));
    vecs.push_back(mk(0,1,D,0, 0,1,A,32'h11111111,3'd4,1,0));
    vecs.push_back(mk(0,1,E,0, 0,1,A,32'h11111111,3'd4,1,1));
    vecs.push_back(mk(0,1,E,1, 1,1,B,32'h22222222,3'd3,1,1));
    vecs.push_back(mk(0,0,'0,1, 1,1,C,32'h33333333,3'd2,1,1));
    vecs.push_back(mk(0,0,'0,1, 1,1,D,32'h44444444,3'd1,1,1));
    vecs.push_back(mk(0,0,'0,1, 1,0,'0,32'h0,3'd0,1,1));
    vecs.push_back(mk(1,0,'0,0, 1,0,'0,32'h0,3'd0,0,0));
    // steady push+pop at level 2 across pointer wrap
    vecs.push_back(mk(0,1,F1,0, 1,1,F1,32'h80000001,3'd1,0,0));
    vecs.push_back(mk(0,1,F2,0, 1,1,F1,32'h80000001,3'd2,1,0));
    vecs.push_back(mk(0,1,F3,1, 1,1,F2,32'h00000002,3'd2,1,0));
    vecs.push_back(mk(0,1,F4,1, 1,1,F3,32'h00000003,3'd2,1,0));
    vecs.push_back(mk(0,1,F5,1, 1,1,F4,32'h00000004,3'd2,1,0));
    vecs.push_back(mk(0,1,F6,1, 1,1,F5,32'h00000000,3'd2,1,0));
    vecs.push_back(mk(0,1,F7,1, 1,1,F6,32'h00000006,3'd2,1,0));
    vecs.push_back(mk(0,1,F8,1, 1,1,F7,32'h00000007,3'd2,1,0));
    vecs.push_back(mk(0,0,'0,1, 1,1,F8,32'h00000008,3'd1,1,0));
    vecs.push_back(mk(0,0,'0,1, 1,0,'0,32'h0,3'd0,1,0));

    // Reset state while RESET is held
    #2;
    check_all("reset", 1, 0, '0, 32'h0, 3'd0, 0, 0);
    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].flush, vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
      check_all($sformatf("vec%0d", i), vecs[i].e_in_ready, vecs[i].e_out_valid,
                vecs[i].e_raw, vecs[i].e_ieee, vecs[i].e_level,
                vecs[i].e_done, vecs[i].e_overflow);
    end

    // Asynchronous reset with three words buffered, then a fresh word reads first
    apply(1, 0, '0, 0);
    apply(0, 1, A, 0);
    apply(0, 1, B, 0);
    apply(0, 1, C, 0);
    check_all("pre_rst", 1, 1, A, 32'h11111111, 3'd3, 1, 0);
    IN_VALID = 1'b0;
    #2;
    RESET = 1'b1;
    #1;
    check_all("mid_rst", 1, 0, '0, 32'h0, 3'd0, 0, 0);
    @(negedge CLK);
    RESET = 1'b0;
    apply(0, 1, G, 0);
    check_all("post_rst1", 1, 1, G, 32'hCAFE0001, 3'd1, 0, 0);
    apply(0, 1, H, 1);
    check_all("post_rst2", 1, 1, H, 32'hCAFE0002, 3'd1, 1, 0);
    apply(0, 0, '0, 1);
    check_all("post_rst3", 1, 0, '0, 32'h0, 3'd0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/result_sink.md
RESULT_SINK -- requirements
Module: result_sink

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32, IEEE-754 word width.
REQ-002 SHALL have parameter EXTRA_BITS, default 2, flag bits above the IEEE word; bit BIT_WIDTH is the non-zero flag.
REQ-003 SHALL have parameter DEPTH, default 4, buffer entries, power of two, >= 2.
REQ-004 SHALL have parameter NUM_RESULTS, default 2, accepted-word count that raises DONE.
REQ-005 SHALL have port CLK, input, 1, single clock; all state changes on its rising edge.
REQ-006 SHALL have port RESET, input, 1, asynchronous, active-high reset.
REQ-007 SHALL have port FLUSH, input, 1, synchronous clear of buffer, counters and flags.
REQ-008 SHALL have port IN_VALID, input, 1, IN_DATA holds a result word.
REQ-009 SHALL have port IN_DATA, input, BIT_WIDTH+EXTRA_BITS, extended-format result from the engine ACC_RESULT.
REQ-010 SHALL have port IN_READY, output, 1, buffer can accept a word.
REQ-011 SHALL have port OUT_VALID, output, 1, OUT_RAW/OUT_IEEE hold the oldest buffered word.
REQ-012 SHALL have port OUT_READY, input, 1, consumer takes the word.
REQ-013 SHALL have port OUT_RAW, output, BIT_WIDTH+EXTRA_BITS, oldest word, unmodified.
REQ-014 SHALL have port OUT_IEEE, output, BIT_WIDTH, OUT_RAW[BIT_WIDTH-1:0] ANDed bitwise with replicated OUT_RAW[BIT_WIDTH].
REQ-015 SHALL have port LEVEL, output, log2(DEPTH)+1, number of buffered words.
REQ-016 SHALL have port DONE, output, 1, sticky; NUM_RESULTS words accepted.
REQ-017 SHALL have port OVERFLOW, output, 1, sticky; a word was offered while full.

Function
REQ-018 SHALL accept a word on a rising edge where IN_VALID=1 and IN_READY=1.
REQ-019 SHALL drive IN_READY = (LEVEL < DEPTH), combinationally from registered state only.
REQ-020 SHALL pop on a rising edge where OUT_VALID=1 and OUT_READY=1.
REQ-021 SHALL drive OUT_VALID = (LEVEL != 0); OUT_RAW/OUT_IEEE SHALL be stable while OUT_VALID=1 and OUT_READY=0.
REQ-022 SHALL give latency of one edge: a word accepted into an empty buffer at edge N appears on OUT_* after edge N.
REQ-023 SHALL preserve FIFO order. Write/read pointers SHALL wrap modulo DEPTH.
REQ-024 SHALL, on simultaneous accept and pop, leave LEVEL unchanged and perform both.
REQ-025 SHALL decide IN_READY from pre-edge LEVEL: when full, an offered word is dropped even if a pop occurs that edge.
REQ-026 SHALL set OVERFLOW on any edge with IN_VALID=1 and IN_READY=0; the buffer SHALL remain unchanged except for the pop.
REQ-027 SHALL keep an accepted-word counter, saturating at NUM_RESULTS.
REQ-028 SHALL set DONE on the edge the counter reaches NUM_RESULTS; later accepts SHALL continue normally.
REQ-029 SHALL make OUT_IEEE=0 whenever OUT_RAW[BIT_WIDTH]=0, regardless of the lower bits.
REQ-030 SHALL, on FLUSH=1, empty the buffer and clear LEVEL, the counter, DONE and OVERFLOW; FLUSH SHALL override any same-edge accept or pop.
REQ-031 SHALL emit no X on outputs when empty: OUT_RAW and OUT_IEEE SHALL read 0.

Reset
REQ-032 SHALL, while RESET=1 (asynchronous, immediate), force pointers, LEVEL, counter, DONE and OVERFLOW to 0; OUT_VALID=0, IN_READY=1, OUT_RAW=0, OUT_IEEE=0.
REQ-033 SHALL discard buffered data when RESET is asserted mid-operation; the first accept after release SHALL land in entry 0.

Verification
REQ-034 SHALL be covered: push {2'b01,32'h3F9D70A4}, OUT_READY=0 -> next cycle OUT_VALID=1, OUT_IEEE=32'h3F9D70A4, LEVEL=1.
REQ-035 SHALL be covered: push {2'b00,32'h3F9D70A4} -> OUT_RAW is the same word, OUT_IEEE=32'h00000000.
REQ-036 SHALL be covered: DEPTH=4; push 5 words with OUT_READY=0 -> IN_READY=0 after the 4th, OVERFLOW=1, 5th word dropped; drain yields words 1-4 in order.
REQ-037 SHALL be covered: LEVEL=2 with push and pop on the same edge -> LEVEL stays 2; the sequence across 8 pushes wraps pointers without loss.
REQ-038 SHALL be covered: NUM_RESULTS=2; accept 2 words -> DONE=1 after the 2nd edge; FLUSH -> DONE=0, LEVEL=0, OVERFLOW=0.
REQ-039 SHALL be covered: RESET pulsed mid-cycle with LEVEL=3 -> outputs go to reset values before the next edge; after release a new word reads back first.
